lpif_link_online_ctrl: RTL

//  Bring-up/teardown sequencer for one LPIF x1 half-rate master link.
//  - Drives tx_online into the auto-sync/concat path and gates the downstream LPIF channel until the link is up.
//  - Sequences PHY ready -> TX online -> far-end RX online -> ACTIVE, with programmable settle delays and a timeout.
//  - Handles retrain and PHY-drop teardown with a drain window.

---
 rtl/lpif_link_online_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lpif_link_online_ctrl.sv
// Bring-up/teardown sequencer for one LPIF x1 half-rate master link; gates downstream valid until ACTIVE.
// Latency: every output is registered from the state/counter registers, one cycle behind the state change.
// Backpressure: none; dstrm_valid_out is dstrm_valid_in ANDed with a registered gate that only moves on clock edges.
module lpif_link_online_ctrl #(
  parameter int CNT_W   = 16,
  parameter int RETRY_W = 4
) (
  input  logic               clk_wr,
  input  logic               rst_wr,
  input  logic               phy_ready,
  input  logic               rx_online,
  input  logic               retrain_req,
  input  logic [CNT_W-1:0]   delay_x_value,
  input  logic [CNT_W-1:0]   delay_y_value,
  input  logic [CNT_W-1:0]   delay_z_value,
  input  logic [CNT_W-1:0]   timeout_value,
  input  logic [1:0]         dstrm_valid_in,
  output logic [1:0]         dstrm_valid_out,
  output logic               tx_online,
  output logic               link_up,
  output logic [2:0]         ctrl_state,
  output logic               timeout_err,
  output logic [RETRY_W-1:0] retrain_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RETRY_W-1:0] RETRY_ONE = {{(RETRY_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               tmo_hit;
  logic               tx_on_dec;

  // Saturating increments: the delay counter must never wrap back onto a
  // compare value, and the retrain counter sticks at all-ones.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_ONE;

  // A zero timeout disables the WAIT_RX watchdog entirely.
  assign tmo_hit = (timeout_value != '0) && (cnt_q == timeout_value - CNT_ONE);

  // Next-state and counter update; every state entry clears the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (phy_ready && !retrain_req) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!phy_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == delay_x_value) begin
          state_d = ST_WAIT_RX;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RX: begin
        // rx_online arriving on the timeout cycle takes priority over the error.
        if (rx_online) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (!rx_online) begin
          state_d = ST_WAIT_RX;
          cnt_d   = '0;
        end else if (cnt_q == delay_y_value) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end
      end
      ST_ACTIVE: begin
        cnt_d = '0;
        if (retrain_req || !phy_ready || !rx_online) begin
          state_d = ST_DRAIN;
          retry_d = retry_inc;
        end
      end
      ST_DRAIN: begin
        // Drain always runs its full length, even if the PHY has gone away.
        if (cnt_q == delay_z_value) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_ERROR: begin
        cnt_d = '0;
        if (retrain_req) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign tx_on_dec = (state_q == ST_WAIT_RX) || (state_q == ST_HOLD) ||
                     (state_q == ST_ACTIVE)  || (state_q == ST_DRAIN);

  // State, counters and the registered output decode.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      tx_online   <= 1'b0;
      link_up     <= 1'b0;
      ctrl_state  <= 3'd0;
      timeout_err <= 1'b0;
      retrain_cnt <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      tx_online   <= tx_on_dec;
      link_up     <= (state_q == ST_ACTIVE);
      ctrl_state  <= state_q;
      timeout_err <= (state_q == ST_ERROR);
      retrain_cnt <= retry_q;
    end
  end

  // link_up doubles as the flit gate: it only changes on a clock edge, so a
  // beat is either passed whole or blocked whole.
  assign dstrm_valid_out = dstrm_valid_in & {2{link_up}};

endmodule
